vga_pattern_sequencer: RTL

Selects which test pattern the VGA test pattern generator shows, and drives its 4-bit pattern-select input. Pattern changes come from user next/prev pulses, or from an auto-cycle dwell timer. A change is applied only at the start of vertical blanking, so a frame never mixes two patterns. The block sits between the debounced board buttons and the pattern generator, on the pixel clock, and takes the same hpos/vpos counters.

---
 rtl/vga_pattern_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vga_pattern_sequencer.sv
// Chooses the VGA test pattern from next/prev pulses or an auto-cycle dwell timer.
// Pattern changes only take effect at the first cycle of vertical blanking.
module vga_pattern_sequencer #(
    parameter int          V_VISIBLE     = 480,
    parameter logic [15:0] ENABLE_MASK   = 16'h0042,
    parameter int          RESET_PATTERN = 1,
    parameter int          DWELL_FRAMES  = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_next,
    input  logic       i_prev,
    input  logic       i_auto_toggle,
    output logic [3:0] o_pattern,
    output logic       o_auto,
    output logic       o_frame_tick
);

    localparam int DW = $clog2(DWELL_FRAMES) + 1;

    // Preferred reset pattern if enabled, else lowest enabled index, else 0.
    function automatic logic [3:0] reset_pick(input logic [15:0] mask, input int rp);
        logic [3:0] pick;
        pick = 4'd0;
        for (int i = 15; i >= 1; i--) begin
            if (mask[i]) pick = 4'(i);
        end
        if (rp >= 1 && rp <= 15) begin
            if (mask[rp]) pick = 4'(rp);
        end
        return pick;
    endfunction

    localparam logic [3:0] RESET_VALUE = reset_pick(ENABLE_MASK, RESET_PATTERN);

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_NEXT = 2'd1,
        PEND_PREV = 2'd2
    } pend_t;

    pend_t          pending_reg;
    logic [DW-1:0]  dwell_reg;
    logic           cond_q;
    logic           cond;
    logic           tick;
    logic [3:0]     up_next;
    logic [3:0]     dn_next;
    logic [4:0]     dn_base;
    logic [3:0]     up_cand [1:15];
    logic [3:0]     dn_cand [1:15];

    assign cond = (i_hpos == 10'd0) && (i_vpos == 10'(V_VISIBLE));
    assign tick = cond && !cond_q;

    // Treat 0 as 16 going down so a search from 0 starts at 15.
    assign dn_base = (o_pattern == 4'd0) ? 5'd16 : {1'b0, o_pattern};

    // Candidate gi is gi steps away from the current pattern on the 1..15 ring.
    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_cand
            logic [4:0] up_sum;
            assign up_sum      = {1'b0, o_pattern} + 5'(gi);
            assign up_cand[gi] = (up_sum > 5'd15) ? 4'(up_sum - 5'd15) : up_sum[3:0];
            assign dn_cand[gi] = (dn_base > 5'(gi)) ? 4'(dn_base - 5'(gi))
                                                    : 4'(dn_base + 5'd15 - 5'(gi));
        end
    endgenerate

    // Nearest enabled candidate wins; with none enabled the pattern is kept.
    always_comb begin
        up_next = o_pattern;
        dn_next = o_pattern;
        for (int k = 15; k >= 1; k--) begin
            if (ENABLE_MASK[up_cand[k]]) up_next = up_cand[k];
            if (ENABLE_MASK[dn_cand[k]]) dn_next = dn_cand[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pattern    <= RESET_VALUE;
            o_auto       <= 1'b0;
            o_frame_tick <= 1'b0;
            pending_reg  <= PEND_NONE;
            dwell_reg    <= '0;
            cond_q       <= 1'b0;
        end else begin
            cond_q       <= cond;
            o_frame_tick <= tick;
            if (tick) begin
                pending_reg <= PEND_NONE;
                case (pending_reg)
                    PEND_NEXT: begin
                        o_pattern <= up_next;
                        dwell_reg <= '0;
                    end
                    PEND_PREV: begin
                        o_pattern <= dn_next;
                        dwell_reg <= '0;
                    end
                    default: begin
                        if (o_auto) begin
                            if (dwell_reg == DW'(DWELL_FRAMES - 1)) begin
                                o_pattern <= up_next;
                                dwell_reg <= '0;
                            end else begin
                                dwell_reg <= dwell_reg + 1'b1;
                            end
                        end else begin
                            dwell_reg <= '0;
                        end
                    end
                endcase
            end
            // A request in the tick cycle is kept for the following frame.
            if (i_next ^ i_prev) pending_reg <= i_next ? PEND_NEXT : PEND_PREV;
            if (i_auto_toggle) begin
                o_auto    <= ~o_auto;
                dwell_reg <= '0;
            end
        end
    end

endmodule
